// File: rtl/register_memory.sv
// Host-visible register memory: a read-only region loaded by the application and
// a read/write region that is zeroed by a clear sequence after reset or on request.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_CLEAR | zeroing RW word cnt_q each cycle; busy high, host writes rejected
//   ST_IDLE  | normal operation; host may write the RW region
module register_memory #(
   parameter int DATA_WIDTH = 16,
   parameter int RO_DEPTH   = 128,
   parameter int RW_DEPTH   = 128,
   localparam int ADDR_WIDTH = $clog2(RO_DEPTH + RW_DEPTH),
   localparam int RO_AW      = $clog2(RO_DEPTH),
   localparam int RW_AW      = $clog2(RW_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_data_out,
   input  logic                  mem_reset,
   input  logic                  ro_wr_en,
   input  logic [RO_AW-1:0]      ro_wr_addr,
   input  logic [DATA_WIDTH-1:0] ro_wr_data,
   input  logic [RW_AW-1:0]      rw_rd_addr,
   output logic [DATA_WIDTH-1:0] rw_rd_data,
   output logic                  busy,
   output logic                  clear_done,
   output logic                  wr_err
);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_IDLE  = 1'b1;

   localparam int               TOTAL_DEPTH = RO_DEPTH + RW_DEPTH;
   localparam logic [RW_AW-1:0] CNT_LAST    = RW_AW'(RW_DEPTH - 1);

   logic [DATA_WIDTH-1:0] ro_mem [RO_DEPTH];
   logic [DATA_WIDTH-1:0] rw_mem [RW_DEPTH];

   logic [0:0]            state_q, state_d;
   logic [RW_AW-1:0]      cnt_q, cnt_d;
   logic                  clear_done_q, clear_done_d;
   logic                  wr_err_q, wr_err_d;
   logic [DATA_WIDTH-1:0] mem_data_out_q, mem_data_out_d;
   logic [DATA_WIDTH-1:0] rw_rd_data_q, rw_rd_data_d;

   logic [31:0]      addr_ext;
   logic             addr_is_ro;
   logic             addr_is_rw;
   logic [RO_AW-1:0] ro_idx;
   logic [RW_AW-1:0] rw_idx;
   logic             host_wr_ok;
   logic             clr_wr;

   // Address decode is done at 32 bits so the out-of-range test stays valid
   // for depths that do not fill the address space.
   always_comb begin
      addr_ext   = 32'(mem_addr);
      addr_is_ro = addr_ext < 32'(RO_DEPTH);
      addr_is_rw = !addr_is_ro && (addr_ext < 32'(TOTAL_DEPTH));
      ro_idx     = RO_AW'(addr_ext);
      rw_idx     = RW_AW'(addr_ext - 32'(RO_DEPTH));
   end

   always_comb begin
      clr_wr     = (state_q == ST_CLEAR);
      host_wr_ok = mem_we && addr_is_rw && (state_q == ST_IDLE) && !mem_reset;
      wr_err_d   = mem_we && !host_wr_ok;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      clear_done_d = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            if (mem_reset) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d      = ST_IDLE;
               cnt_d        = '0;
               clear_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (mem_reset) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
      endcase
   end

   // Reads sample the arrays before this edge's writes land: read-before-write.
   always_comb begin
      mem_data_out_d = '0;
      if (addr_is_ro) begin
         mem_data_out_d = ro_mem[ro_idx];
      end else if (addr_is_rw) begin
         mem_data_out_d = rw_mem[rw_idx];
      end
      rw_rd_data_d = rw_mem[rw_rd_addr];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_CLEAR;
         cnt_q          <= '0;
         clear_done_q   <= 1'b0;
         wr_err_q       <= 1'b0;
         mem_data_out_q <= '0;
         rw_rd_data_q   <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         clear_done_q   <= clear_done_d;
         wr_err_q       <= wr_err_d;
         mem_data_out_q <= mem_data_out_d;
         rw_rd_data_q   <= rw_rd_data_d;
      end
   end

   // Arrays carry no reset; the clear sequence initialises the RW region.
   always_ff @(posedge clk) begin
      if (ro_wr_en) begin
         ro_mem[ro_wr_addr] <= ro_wr_data;
      end
      if (clr_wr) begin
         rw_mem[cnt_q] <= '0;
      end else if (host_wr_ok) begin
         rw_mem[rw_idx] <= mem_data_in;
      end
   end

   assign busy         = (state_q == ST_CLEAR);
   assign clear_done   = clear_done_q;
   assign wr_err       = wr_err_q;
   assign mem_data_out = mem_data_out_q;
   assign rw_rd_data   = rw_rd_data_q;

endmodule

// File: tb/tb_register_memory.sv
// Self-checking bench for register_memory: scenario tasks with a queue of
// expected host read data popped one cycle after each read address is driven.
module tb_register_memory;

   logic        clk;
   logic        rst;
   logic [7:0]  mem_addr;
   logic [15:0] mem_data_in;
   logic        mem_we;
   logic [15:0] mem_data_out;
   logic        mem_reset;
   logic        ro_wr_en;
   logic [6:0]  ro_wr_addr;
   logic [15:0] ro_wr_data;
   logic [6:0]  rw_rd_addr;
   logic [15:0] rw_rd_data;
   logic        busy;
   logic        clear_done;
   logic        wr_err;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   register_memory dut (
      .clk          (clk),
      .rst          (rst),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_we       (mem_we),
      .mem_data_out (mem_data_out),
      .mem_reset    (mem_reset),
      .ro_wr_en     (ro_wr_en),
      .ro_wr_addr   (ro_wr_addr),
      .ro_wr_data   (ro_wr_data),
      .rw_rd_addr   (rw_rd_addr),
      .rw_rd_data   (rw_rd_data),
      .busy         (busy),
      .clear_done   (clear_done),
      .wr_err       (wr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs until busy falls (bounded), counting cycles and any early clear_done.
   task automatic measure_clear(output int cycles, output int pulses, output logic done_fall);
      cycles = 0;
      pulses = 0;
      while (busy === 1'b1 && cycles < 300) begin
         if (clear_done === 1'b1) pulses++;
         step();
         cycles++;
      end
      done_fall = clear_done;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      mem_we = 1'b1;
      mem_addr = 8'h85;
      mem_data_in = 16'hFFFF;
      step();
      step();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", busy); end
      checks++;
      if (mem_data_out !== 16'h0000) begin errors++; $display("FAIL reset_mem_data_out got %h exp 0000", mem_data_out); end
      checks++;
      if (rw_rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rw_rd_data got %h exp 0000", rw_rd_data); end
      checks++;
      if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_clear_done got %b exp 0", clear_done); end
      checks++;
      if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err got %b exp 0", wr_err); end
      mem_we = 1'b0;
   endtask

   task automatic test_initial_clear();
      int cycles, pulses;
      logic done_fall;
      logic [15:0] exp;
      rst = 1'b1;
      measure_clear(cycles, pulses, done_fall);
      checks++;
      if (cycles != 128) begin errors++; $display("FAIL init_busy_cycles got %0d exp 128", cycles); end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL init_early_done got %0d exp 0", pulses); end
      checks++;
      if (done_fall !== 1'b1) begin errors++; $display("FAIL init_done_at_fall got %b exp 1", done_fall); end
      step();
      checks++;
      if (clear_done !== 1'b0) begin errors++; $display("FAIL init_done_single got %b exp 0", clear_done); end
      for (int a = 128; a < 256; a++) begin
         mem_addr = 8'(a);
         exp_q.push_back(16'h0000);
         step();
         exp = exp_q.pop_front();
         checks++;
         if (mem_data_out !== exp) begin errors++; $display("FAIL init_sweep addr %h got %h exp %h", a, mem_data_out, exp); end
      end
   endtask

   task automatic test_rw_write_read();
      logic [15:0] exp;
      mem_addr = 8'h85;
      mem_data_in = 16'hBEEF;
      mem_we = 1'b1;
      step();
      mem_we = 1'b0;
      checks++;
      if (wr_err !== 1'b0) begin errors++; $display("FAIL rw_write_err got %b exp 0", wr_err); end
      exp_q.push_back(16'hBEEF);
      rw_rd_addr = 7'd5;
      step();
      exp = exp_q.pop_front();
      checks++;
      if (mem_data_out !== exp) begin errors++; $display("FAIL rw_host_read got %h exp %h", mem_data_out, exp); end
      checks++;
      if (rw_rd_data !== 16'hBEEF) begin errors++; $display("FAIL rw_app_read got %h exp beef", rw_rd_data); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] model [8];
      logic [15:0] exp;
      for (int i = 0; i < 8; i++) begin
         model[i] = 16'($urandom);
         mem_addr = 8'(8'h80 + i * 9);
         mem_data_in = model[i];
         mem_we = 1'b1;
         step();
      end
      mem_we = 1'b0;
      rw_rd_addr = 7'd27;
      for (int i = 0; i < 8; i++) begin
         mem_addr = 8'(8'h80 + i * 9);
         exp_q.push_back(model[i]);
         step();
         exp = exp_q.pop_front();
         checks++;
         if (mem_data_out !== exp) begin errors++; $display("FAIL b2b_read idx %0d got %h exp %h", i, mem_data_out, exp); end
      end
      checks++;
      if (rw_rd_data !== model[3]) begin errors++; $display("FAIL b2b_app_read got %h exp %h", rw_rd_data, model[3]); end
      mem_addr = 8'h80;
      mem_data_in = ~model[0];
      mem_we = 1'b1;
      exp_q.push_back(model[0]);
      step();
      mem_we = 1'b0;
      exp = exp_q.pop_front();
      checks++;
      if (mem_data_out !== exp) begin errors++; $display("FAIL rw_rbw_old got %h exp %h", mem_data_out, exp); end
      exp_q.push_back(~model[0]);
      step();
      exp = exp_q.pop_front();
      checks++;
      if (mem_data_out !== exp) begin errors++; $display("FAIL rw_rbw_new got %h exp %h", mem_data_out, exp); end
   endtask

   task automatic test_ro_write();
      logic [15:0] exp;
      mem_addr = 8'h10;
      mem_data_in = 16'h1234;
      mem_we = 1'b1;
      step();
      mem_we = 1'b0;
      checks++;
      if (wr_err !== 1'b1) begin errors++; $display("FAIL ro_host_wr_err got %b exp 1", wr_err); end
      ro_wr_en = 1'b1;
      ro_wr_addr = 7'h10;
      ro_wr_data = 16'h5A5A;
      step();
      ro_wr_en = 1'b0;
      checks++;
      if (wr_err !== 1'b0) begin errors++; $display("FAIL ro_wr_err_single got %b exp 0", wr_err); end
      exp_q.push_back(16'h5A5A);
      step();
      exp = exp_q.pop_front();
      checks++;
      if (mem_data_out !== exp) begin errors++; $display("FAIL ro_read got %h exp %h", mem_data_out, exp); end
   endtask

   task automatic test_ro_rbw();
      logic [15:0] exp;
      ro_wr_en = 1'b1;
      ro_wr_addr = 7'd3;
      ro_wr_data = 16'h0001;
      step();
      mem_addr = 8'h03;
      ro_wr_data = 16'h0002;
      exp_q.push_back(16'h0001);
      step();
      ro_wr_en = 1'b0;
      exp = exp_q.pop_front();
      checks++;
      if (mem_data_out !== exp) begin errors++; $display("FAIL ro_rbw_old got %h exp %h", mem_data_out, exp); end
      exp_q.push_back(16'h0002);
      step();
      exp = exp_q.pop_front();
      checks++;
      if (mem_data_out !== exp) begin errors++; $display("FAIL ro_rbw_new got %h exp %h", mem_data_out, exp); end
   endtask

   task automatic test_clear_abort();
      int cycles, pulses, early;
      logic done_fall;
      logic [15:0] exp;
      mem_addr = 8'h90;
      mem_data_in = 16'hAAAA;
      mem_we = 1'b1;
      step();
      // Write in the same cycle as mem_reset while IDLE must be dropped.
      mem_data_in = 16'h5555;
      mem_reset = 1'b1;
      step();
      mem_reset = 1'b0;
      mem_we = 1'b0;
      checks++;
      if (wr_err !== 1'b1) begin errors++; $display("FAIL abort_wr_err_mem_reset got %b exp 1", wr_err); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_start got %b exp 1", busy); end
      early = 0;
      for (int k = 0; k < 60; k++) begin
         if (clear_done === 1'b1) early++;
         if (k == 6) begin
            checks++;
            if (rw_rd_data !== 16'hAAAA) begin errors++; $display("FAIL abort_uncleared_word got %h exp aaaa", rw_rd_data); end
         end
         if (k == 11) begin
            mem_we = 1'b0;
            checks++;
            if (wr_err !== 1'b1) begin errors++; $display("FAIL abort_wr_err_clear got %b exp 1", wr_err); end
         end
         if (k == 21) begin
            exp = exp_q.pop_front();
            checks++;
            if (mem_data_out !== exp) begin errors++; $display("FAIL abort_read_in_clear got %h exp %h", mem_data_out, exp); end
         end
         if (k == 31) begin
            checks++;
            if (rw_rd_data !== 16'h0000) begin errors++; $display("FAIL abort_cleared_word got %h exp 0000", rw_rd_data); end
         end
         if (k == 5) rw_rd_addr = 7'd16;
         if (k == 10) begin
            mem_addr = 8'h88;
            mem_data_in = 16'h1111;
            mem_we = 1'b1;
         end
         if (k == 20) begin
            mem_addr = 8'h80;
            exp_q.push_back(16'h0000);
         end
         if (k == 30) rw_rd_addr = 7'd0;
         step();
      end
      mem_reset = 1'b1;
      mem_we = 1'b1;
      mem_addr = 8'h86;
      mem_data_in = 16'h7777;
      step();
      mem_reset = 1'b0;
      mem_we = 1'b0;
      checks++;
      if (wr_err !== 1'b1) begin errors++; $display("FAIL abort_wr_err_restart got %b exp 1", wr_err); end
      measure_clear(cycles, pulses, done_fall);
      checks++;
      if (cycles != 128) begin errors++; $display("FAIL abort_busy_cycles got %0d exp 128", cycles); end
      checks++;
      if (pulses + early != 0) begin errors++; $display("FAIL abort_early_done got %0d exp 0", pulses + early); end
      checks++;
      if (done_fall !== 1'b1) begin errors++; $display("FAIL abort_done_at_fall got %b exp 1", done_fall); end
      step();
      checks++;
      if (clear_done !== 1'b0) begin errors++; $display("FAIL abort_done_single got %b exp 0", clear_done); end
      for (int i = 0; i < 3; i++) begin
         mem_addr = (i == 0) ? 8'h86 : ((i == 1) ? 8'h88 : 8'h90);
         exp_q.push_back(16'h0000);
         step();
         exp = exp_q.pop_front();
         checks++;
         if (mem_data_out !== exp) begin errors++; $display("FAIL abort_after_clear addr %h got %h exp %h", mem_addr, mem_data_out, exp); end
      end
   endtask

   task automatic test_reset_midclear();
      int cycles, pulses;
      logic done_fall;
      mem_addr = 8'h10;
      rw_rd_addr = 7'd5;
      mem_reset = 1'b1;
      step();
      mem_reset = 1'b0;
      for (int k = 0; k < 30; k++) step();
      rst = 1'b0;
      step();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b exp 1", busy); end
      checks++;
      if (mem_data_out !== 16'h0000) begin errors++; $display("FAIL midrst_mem_data_out got %h exp 0000", mem_data_out); end
      checks++;
      if (clear_done !== 1'b0) begin errors++; $display("FAIL midrst_clear_done got %b exp 0", clear_done); end
      rst = 1'b1;
      measure_clear(cycles, pulses, done_fall);
      checks++;
      if (cycles != 128) begin errors++; $display("FAIL midrst_busy_cycles got %0d exp 128", cycles); end
      checks++;
      if (pulses != 0 || done_fall !== 1'b1) begin errors++; $display("FAIL midrst_done got early %0d fall %b exp 0 1", pulses, done_fall); end
      step();
      checks++;
      if (mem_data_out !== 16'h5A5A) begin errors++; $display("FAIL midrst_ro_kept got %h exp 5a5a", mem_data_out); end
   endtask

   initial begin
      rst = 1'bx;
      mem_addr = 8'h00;
      mem_data_in = 16'h0000;
      mem_we = 1'b0;
      mem_reset = 1'b0;
      ro_wr_en = 1'b0;
      ro_wr_addr = 7'd0;
      ro_wr_data = 16'h0000;
      rw_rd_addr = 7'd0;
      #2;
      test_reset();
      test_initial_clear();
      test_rw_write_read();
      test_back_to_back();
      test_ro_write();
      test_ro_rbw();
      test_clear_abort();
      test_reset_midclear();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_memory.md
REGISTER_MEMORY -- requirements
Module: register_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, register word width in bits.
REQ-002 SHALL have parameter RO_DEPTH, default 128, number of read-only words at addresses 0..RO_DEPTH-1.
REQ-003 SHALL have parameter RW_DEPTH, default 128, number of read/write words at addresses RO_DEPTH..RO_DEPTH+RW_DEPTH-1.
REQ-004 SHALL derive ADDR_WIDTH = clog2(RO_DEPTH+RW_DEPTH), RO_AW = clog2(RO_DEPTH) and RW_AW = clog2(RW_DEPTH) as local constants.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port mem_addr, input, ADDR_WIDTH: host word address.
REQ-008 SHALL have port mem_data_in, input, DATA_WIDTH: host write data.
REQ-009 SHALL have port mem_we, input, 1 bit: host write strobe, one word per cycle high.
REQ-010 SHALL have port mem_data_out, output, DATA_WIDTH: host read data, registered.
REQ-011 SHALL have port mem_reset, input, 1 bit: request to clear the RW region.
REQ-012 SHALL have port ro_wr_en, input, 1 bit: application write strobe into the RO region.
REQ-013 SHALL have port ro_wr_addr, input, RO_AW: application RO write address.
REQ-014 SHALL have port ro_wr_data, input, DATA_WIDTH: application RO write data.
REQ-015 SHALL have port rw_rd_addr, input, RW_AW: application RW read address (0-based within the RW region).
REQ-016 SHALL have port rw_rd_data, output, DATA_WIDTH: application RW read data, registered.
REQ-017 SHALL have port busy, output, 1 bit: clear sequence in progress.
REQ-018 SHALL have port clear_done, output, 1 bit: one-cycle pulse when a clear completes.
REQ-019 SHALL have port wr_err, output, 1 bit: one-cycle pulse when a host write is rejected.

Function
REQ-020 SHALL implement an FSM with states CLEAR and IDLE; the reset state is CLEAR with clear counter 0.
REQ-021 In CLEAR, SHALL write 0 to RW word n in the cycle the counter equals n, incrementing by 1 per cycle.
REQ-022 In CLEAR, when the counter equals RW_DEPTH-1, SHALL write that word, go to IDLE next cycle and pulse clear_done in the same cycle that busy falls.
REQ-023 SHALL drive busy high in every cycle the FSM is in CLEAR, including the cycles immediately after reset release.
REQ-024 In IDLE, mem_reset high SHALL move the FSM to CLEAR with counter 0 in the next cycle.
REQ-025 In CLEAR, mem_reset high SHALL restart the counter at 0 in the next cycle, with no clear_done pulse for the aborted pass.
REQ-026 Host reads SHALL have 1-cycle latency: mem_data_out in cycle t+1 holds the word at mem_addr sampled in cycle t, in every cycle and state.
REQ-027 A host read of an address >= RO_DEPTH+RW_DEPTH SHALL return 0.
REQ-028 A host write to an RW address in IDLE, with mem_reset low, SHALL update that word on the clock edge.
REQ-029 A host write SHALL be dropped, with wr_err pulsed in the next cycle, if any of these holds: the address is < RO_DEPTH; the address is >= RO_DEPTH+RW_DEPTH; the FSM is in CLEAR; mem_reset is high in the same cycle.
REQ-030 ro_wr_en SHALL write ro_wr_data to RO word ro_wr_addr in any state; it has no interaction with busy.
REQ-031 A same-cycle read and write to the same word, on either port, SHALL be read-before-write: the read returns the old value.
REQ-032 rw_rd_data SHALL have 1-cycle latency and operate in every state; during CLEAR it returns the current word content, which is 0 for words already cleared.
REQ-033 RO contents SHALL be undefined until first written by ro_wr_en; RW contents SHALL be undefined only until the first clear completes.

Reset
REQ-034 While rst is low: state SHALL be CLEAR, counter 0, busy 1, mem_data_out 0, rw_rd_data 0, clear_done 0, wr_err 0.
REQ-035 Asserting rst mid-clear or mid-write SHALL abort the operation; after release a full clear of all RW_DEPTH words SHALL run again.
REQ-036 Memory arrays SHALL NOT be reset by rst; the clear sequence alone initialises the RW region.

Verification
REQ-037 Release rst -> busy high exactly 128 cycles, clear_done pulses once in the cycle busy falls, and a read of every address 128..255 returns 0x0000.
REQ-038 In IDLE, write 0xBEEF to 0x85, then read 0x85 -> mem_data_out = 0xBEEF one cycle after the read address; rw_rd_addr = 5 -> rw_rd_data = 0xBEEF.
REQ-039 Host write 0x1234 to 0x10 -> wr_err pulses once; ro_wr_en writes 0x5A5A to RO address 0x10; host read of 0x10 -> 0x5A5A.
REQ-040 Pulse mem_reset at counter 60 of a clear -> counter restarts at 0, busy stays high 128 more cycles, clear_done pulses exactly once.
REQ-041 Host write during CLEAR, or in the same cycle as mem_reset -> wr_err pulses and the word reads 0x0000 after the clear.
REQ-042 Same-cycle host read and ro_wr_en to RO address 3 (old 0x0001, new 0x0002) -> mem_data_out = 0x0001; the next read returns 0x0002.
